// File: rtl/key_sel_filter.sv
// key_sel_filter: synchronised, debounced active-low key front end
// giving a one-cycle press pulse and a toggling mux select level.
module key_sel_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic sel_out
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    P_FILTER,
    DOWN,
    R_FILTER
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_key_d1;
  logic          r_key_s;
  logic          r_flag;
  logic          r_kstate;
  logic          r_sel;
  logic          w_flag_nxt;
  logic          w_kstate_nxt;
  logic          w_sel_nxt;
  logic          w_cnt_done;

  // Two-flop synchroniser, idles at released (1).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_d1 <= 1'b1;
      r_key_s  <= 1'b1;
    end else begin
      r_key_d1 <= key_in;
      r_key_s  <= r_key_d1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_flag   <= 1'b0;
      r_kstate <= 1'b0;
      r_sel    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_flag   <= w_flag_nxt;
      r_kstate <= w_kstate_nxt;
      r_sel    <= w_sel_nxt;
    end
  end

  assign w_cnt_done = (r_cnt == CMAX);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_flag_nxt   = 1'b0;
    w_kstate_nxt = r_kstate;
    w_sel_nxt    = r_sel;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_key_s) begin
          w_state_nxt = P_FILTER;
        end
      end
      P_FILTER: begin
        if (r_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt  = DOWN;
          w_cnt_nxt    = '0;
          w_flag_nxt   = 1'b1;
          w_kstate_nxt = 1'b1;
          w_sel_nxt    = ~r_sel;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DOWN: begin
        w_cnt_nxt = '0;
        if (r_key_s) begin
          w_state_nxt = R_FILTER;
        end
      end
      R_FILTER: begin
        // A bounce back low returns silently; no second flag.
        if (!r_key_s) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_kstate_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_flag  = r_flag;
  assign key_state = r_kstate;
  assign sel_out   = r_sel;

endmodule

// File: tb/tb_key_sel_filter.sv
// Bench for key_sel_filter: run-length debounce model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_key_sel_filter;

  localparam int CM = 9;
  localparam int LAT = CM + 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_flag;
  logic key_state;
  logic sel_out;

  int n_chk = 0;
  int n_pass = 0;
  int n_flags = 0;
  int n_cyc = 0;

  logic m_d1, m_s, m_lvl, m_flag, m_sel;
  int   m_run;

  key_sel_filter #(.CNT_MAX(CM)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state),
    .sel_out   (sel_out)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk3(input string nm,
                      input logic [2:0] act,
                      input logic [2:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got %b want %b",
                  nm, n_cyc, act, exp);
  endtask

  task automatic chk_int(input string nm,
                         input int act,
                         input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d want %0d",
                  nm, act, exp);
  endtask

  task automatic m_reset();
    m_d1   = 1'b1;
    m_s    = 1'b1;
    m_lvl  = 1'b0;
    m_flag = 1'b0;
    m_sel  = 1'b0;
    m_run  = 0;
  endtask

  // Model: the debounced level flips once CM+2 consecutive
  // synchronised samples disagree with it; a press flips sel.
  initial begin : model
    logic ks;
    m_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_reset();
      end else begin
        ks = m_s;
        m_s = m_d1;
        m_d1 = key_in;
        m_flag = 1'b0;
        if (~ks == m_lvl) m_run = 0;
        else m_run = m_run + 1;
        if (m_run == CM + 2) begin
          m_run = 0;
          m_lvl = ~m_lvl;
          if (m_lvl) begin
            m_flag = 1'b1;
            m_sel = ~m_sel;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge sys_clk);
      n_cyc++;
      if (key_flag === 1'b1) n_flags++;
      chk3("model", {key_flag, key_state, sel_out},
           {m_flag, m_lvl, m_sel});
    end
  end

  task automatic hold(input logic k, input int n);
    key_in = k;
    repeat (n) begin
      @(negedge sys_clk);
      #2;
    end
  endtask

  // mode 0: wait for key_flag=1; mode 1: wait for key_state=0
  task automatic wait_ev(input int mode, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sys_clk);
      if ((mode == 0 && key_flag === 1'b1) ||
          (mode == 1 && key_state === 1'b0)) begin
        n = i;
        break;
      end
    end
    #2;
  endtask

  initial begin : stim
    int n;
    int f0;
    sys_rst_n = 1'b0;
    key_in = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      #2;
    end
    chk3("in_reset", {key_flag, key_state, sel_out}, 3'b000);
    sys_rst_n = 1'b1;
    hold(1'b1, 4);
    chk3("after_reset", {key_flag, key_state, sel_out}, 3'b000);

    f0 = n_flags;
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 4);
    hold(1'b1, 20);
    chk_int("bounce_flags", n_flags - f0, 0);
    chk3("bounce_out", {key_flag, key_state, sel_out}, 3'b000);

    key_in = 1'b0;
    wait_ev(0, n);
    chk_int("press_lat", n, LAT);
    chk3("press_pulse", {key_flag, key_state, sel_out}, 3'b111);
    hold(1'b0, 1);
    chk3("press_after", {key_flag, key_state, sel_out}, 3'b011);
    f0 = n_flags;
    key_in = 1'b1;
    wait_ev(1, n);
    chk_int("release_lat", n, LAT);
    hold(1'b1, 8);
    chk_int("release_flags", n_flags - f0, 0);
    chk3("released", {key_flag, key_state, sel_out}, 3'b001);

    hold(1'b0, 20);
    chk3("press2", {key_flag, key_state, sel_out}, 3'b010);
    f0 = n_flags;
    hold(1'b1, 3);
    hold(1'b0, 20);
    chk_int("blip_flags", n_flags - f0, 0);
    chk3("blip_state", {key_flag, key_state, sel_out}, 3'b010);
    hold(1'b1, 20);
    chk3("blip_rel", {key_flag, key_state, sel_out}, 3'b000);

    f0 = n_flags;
    hold(1'b0, 20);
    chk3("two_a", {key_flag, key_state, sel_out}, 3'b011);
    hold(1'b1, 20);
    hold(1'b0, 20);
    chk3("two_b", {key_flag, key_state, sel_out}, 3'b010);
    hold(1'b1, 20);
    chk_int("two_flags", n_flags - f0, 2);

    f0 = n_flags;
    for (int i = 0; i < 40; i++) hold(i[0], 1);
    hold(1'b1, 5);
    chk_int("toggle_flags", n_flags - f0, 0);
    chk3("toggle_out", {key_flag, key_state, sel_out}, 3'b000);

    hold(1'b0, 20);
    hold(1'b1, 20);
    chk3("pre_rst", {key_flag, key_state, sel_out}, 3'b001);
    // Nine edges sampling low leaves the filter count at 6.
    hold(1'b0, 9);
    sys_rst_n = 1'b0;
    #1;
    chk3("rst_clear", {key_flag, key_state, sel_out}, 3'b000);
    repeat (3) begin
      @(negedge sys_clk);
      #2;
    end
    sys_rst_n = 1'b1;
    wait_ev(0, n);
    chk_int("rst_relat", n, LAT);
    chk3("rst_press", {key_flag, key_state, sel_out}, 3'b111);
    hold(1'b1, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
